// File: rtl/cb_slave_mem.sv
// rtl/cb_slave_mem.sv - crossbar slave word memory with programmable wait states; optional CB_SLAVE_MEM_STATS_EN access counters
`timescale 1ns/1ps
module cb_slave_mem #(
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] INIT_VAL    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        i_cb_s_req,
    input  logic        i_cb_s_cmd,
    input  logic [31:0] i_cb_s_addr,
    input  logic [31:0] i_cb_s_wdata,
    output logic        o_s_cb_ack,
    output logic [31:0] o_s_cb_rdata
`ifdef CB_SLAVE_MEM_STATS_EN
    ,
    output logic [15:0] o_rd_cnt,
    output logic [15:0] o_wr_cnt
`endif
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      cnt_q;
    logic            cmd_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [31:0]     mem [DEPTH];

    logic            cur_cmd;
    logic [AW-1:0]   cur_idx;
    logic [31:0]     cur_wdata;

    logic            unused_addr_bits;
    assign unused_addr_bits = ^{i_cb_s_addr[31:AW+2], i_cb_s_addr[1:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_cb_s_req) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the access commits on the capture edge itself, so use the live inputs.
    always_comb begin
        cur_cmd   = cmd_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            cur_cmd   = i_cb_s_cmd;
            cur_idx   = i_cb_s_addr[AW+1:2];
            cur_wdata = i_cb_s_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            cmd_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            o_s_cb_ack   <= 1'b0;
            o_s_cb_rdata <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_VAL;
            end
`ifdef CB_SLAVE_MEM_STATS_EN
            o_rd_cnt     <= 16'd0;
            o_wr_cnt     <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            o_s_cb_ack   <= (state_d == ST_ACK);
            o_s_cb_rdata <= 32'd0;

            if (state_q == ST_IDLE && i_cb_s_req) begin
                cmd_q   <= i_cb_s_cmd;
                idx_q   <= i_cb_s_addr[AW+1:2];
                wdata_q <= i_cb_s_wdata;
                cnt_q   <= CNT_LOAD;
            end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (state_d == ST_ACK) begin
                if (cur_cmd) begin
                    mem[cur_idx] <= cur_wdata;
`ifdef CB_SLAVE_MEM_STATS_EN
                    if (o_wr_cnt != 16'hFFFF) o_wr_cnt <= o_wr_cnt + 16'd1;
`endif
                end else begin
                    o_s_cb_rdata <= mem[cur_idx];
`ifdef CB_SLAVE_MEM_STATS_EN
                    if (o_rd_cnt != 16'hFFFF) o_rd_cnt <= o_rd_cnt + 16'd1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_cb_slave_mem.sv
// tb/tb_cb_slave_mem.sv - randomized scoreboard bench for cb_slave_mem (wait-state and zero-wait instances)
`timescale 1ns/1ps
module tb_cb_slave_mem;

    localparam int          DEP0  = 16;
    localparam int          WC0   = 2;
    localparam logic [31:0] INIT0 = 32'hDEAD_BEEF;
    localparam int          DEP1  = 4;
    localparam int          WC1   = 0;
    localparam logic [31:0] INIT1 = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        req [2];
    logic        cmd [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        ack [2];
    logic [31:0] rdata [2];
`ifdef CB_SLAVE_MEM_STATS_EN
    logic [15:0] rd_cnt [2];
    logic [15:0] wr_cnt [2];
`endif

    cb_slave_mem #(.DEPTH(DEP0), .WAIT_CYCLES(WC0), .INIT_VAL(INIT0)) u_dut0 (
        .clk(clk), .arst(arst),
        .i_cb_s_req(req[0]), .i_cb_s_cmd(cmd[0]), .i_cb_s_addr(addr[0]), .i_cb_s_wdata(wdata[0]),
        .o_s_cb_ack(ack[0]), .o_s_cb_rdata(rdata[0])
`ifdef CB_SLAVE_MEM_STATS_EN
        , .o_rd_cnt(rd_cnt[0]), .o_wr_cnt(wr_cnt[0])
`endif
    );

    cb_slave_mem #(.DEPTH(DEP1), .WAIT_CYCLES(WC1), .INIT_VAL(INIT1)) u_dut1 (
        .clk(clk), .arst(arst),
        .i_cb_s_req(req[1]), .i_cb_s_cmd(cmd[1]), .i_cb_s_addr(addr[1]), .i_cb_s_wdata(wdata[1]),
        .o_s_cb_ack(ack[1]), .o_s_cb_rdata(rdata[1])
`ifdef CB_SLAVE_MEM_STATS_EN
        , .o_rd_cnt(rd_cnt[1]), .o_wr_cnt(wr_cnt[1])
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        is_wr;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    logic [31:0] mdl [2][256];
    int          rd_m [2];
    int          wr_m [2];
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) mdl[d][i] = (d == 0) ? INIT0 : INIT1;
            rd_m[d] = 0;
            wr_m[d] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic mon(input int d);
        exp_t e;
        int   n;
        n = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (ack[d]) begin
            if (n == 0) begin
                check($sformatf("d%0d_unexpected_ack", d), 32'(ack[d]), 32'd0);
            end else begin
                if (d == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                check($sformatf("d%0d_ack_cycle", d), 32'(cyc), 32'(e.due));
                check($sformatf("d%0d_rdata", d), rdata[d], e.rdata);
                if (e.is_wr) wr_m[d]++;
                else         rd_m[d]++;
`ifdef CB_SLAVE_MEM_STATS_EN
                check($sformatf("d%0d_rd_cnt", d), 32'(rd_cnt[d]), 32'(rd_m[d]));
                check($sformatf("d%0d_wr_cnt", d), 32'(wr_cnt[d]), 32'(wr_m[d]));
`endif
            end
        end else begin
            check($sformatf("d%0d_rdata_idle", d), rdata[d], 32'd0);
            if (n > 0) begin
                e = (d == 0) ? exp_q0[0] : exp_q1[0];
                if (cyc > e.due) begin
                    check($sformatf("d%0d_missing_ack", d), 32'(ack[d]), 32'd1);
                    if (d == 0) void'(exp_q0.pop_front());
                    else        void'(exp_q1.pop_front());
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) mon(d);
    end

    // Issue one transfer to DUT d; after capture, drive post cycles of junk (or dropped req) that must be ignored.
    task automatic issue(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input bit drop = 1'b0, input int post = -1, input bit now = 1'b0);
        exp_t e;
        int   wc, dep, idx, np;
        wc  = (d == 0) ? WC0 : WC1;
        dep = (d == 0) ? DEP0 : DEP1;
        if (!now) @(negedge clk);
        req[0]   = 1'b0;
        req[1]   = 1'b0;
        req[d]   = 1'b1;
        cmd[d]   = wr;
        addr[d]  = a;
        wdata[d] = wd;
        idx      = int'(a[31:2] % 30'(dep));
        e.due    = cyc + 1 + wc;
        e.is_wr  = wr;
        e.rdata  = wr ? 32'd0 : mdl[d][idx];
        if (wr) mdl[d][idx] = wd;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        np = (post < 0) ? wc + 1 : post;
        repeat (np) begin
            @(negedge clk);
            req[d]   = drop ? 1'b0 : 1'($urandom);
            cmd[d]   = 1'($urandom);
            addr[d]  = $urandom;
            wdata[d] = $urandom;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req[0] = 1'b0;
            req[1] = 1'b0;
        end
    endtask

    // Requests are held high throughout reset; none of them may be captured.
    task automatic do_reset(input int n);
        @(negedge clk);
        arst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d]   = 1'b1;
            cmd[d]   = 1'($urandom);
            addr[d]  = $urandom;
            wdata[d] = $urandom;
        end
        model_reset();
        repeat (n) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_reset_ack", d), 32'(ack[d]), 32'd0);
            check($sformatf("d%0d_reset_rdata", d), rdata[d], 32'd0);
`ifdef CB_SLAVE_MEM_STATS_EN
            check($sformatf("d%0d_reset_rd_cnt", d), 32'(rd_cnt[d]), 32'd0);
            check($sformatf("d%0d_reset_wr_cnt", d), 32'(wr_cnt[d]), 32'd0);
`endif
        end
        arst   = 1'b1;
        req[0] = 1'b0;
        req[1] = 1'b0;
    endtask

    initial begin
        int          d;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; cmd[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
        end
        model_reset();
        do_reset(2);
        // first edge after release captures; zero-wait read of reset contents
        issue(1, 1'b0, 32'h0000_0004, 32'd0, 1'b0, -1, 1'b1);
        issue(0, 1'b0, 32'h0000_0010, 32'd0);

        issue(0, 1'b1, 32'h0000_0004, 32'hA5A5_0001);
        issue(0, 1'b0, 32'h0000_0004, 32'd0);
        issue(0, 1'b1, 32'h0000_0040, 32'h1234_5678);
        issue(0, 1'b0, 32'h0000_0000, 32'd0);
        issue(0, 1'b1, 32'hFFFF_FFFF, 32'h0BAD_F00D, 1'b1);
        issue(0, 1'b0, 32'h0000_003C, 32'd0);
        issue(1, 1'b1, 32'h0000_0013, 32'h7777_0001);
        issue(1, 1'b0, 32'h8000_0003, 32'd0);
        idle(3);

        // aborted write: reset lands while the write is still waiting
        issue(0, 1'b1, 32'h0000_0008, 32'hCAFE_0008, 1'b0, 1);
        do_reset(2);
        issue(0, 1'b0, 32'h0000_0008, 32'd0);

        for (int t = 0; t < 400; t++) begin
            d = $urandom_range(0, 1);
            a = $urandom;
            issue(d, 1'($urandom), a, $urandom, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
            if (t == 200) begin
                issue(0, 1'b1, $urandom, $urandom, 1'b0, 1);
                do_reset(1);
            end
        end
        idle(2);
        for (int i = 0; i < 50 && (exp_q0.size() + exp_q1.size()) > 0; i++) @(negedge clk);
        check("drain_pending", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cb_slave_mem.md
CB_SLAVE_MEM -- requirements
Module: cb_slave_mem

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit words held; power of two, range 2..256.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before ack; range 0..15.
REQ-003 Parameter INIT_VAL, default 32'h0000_0000, reset contents of every word.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: arst  input  1  reset, synchronous, active-low.
REQ-006 Port: i_cb_s_req  input  1  request from crossbar slave port.
REQ-007 Port: i_cb_s_cmd  input  1  0 = read, 1 = write.
REQ-008 Port: i_cb_s_addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2].
REQ-009 Port: i_cb_s_wdata  input  32  write data.
REQ-010 Port: o_s_cb_ack  output  1  one-cycle completion pulse.
REQ-011 Port: o_s_cb_rdata  output  32  read data, valid only while o_s_cb_ack = 1.

Function
REQ-012 The block SHALL implement states IDLE, WAIT, ACK; all outputs registered.
REQ-013 IDLE: i_cb_s_req = 1 at an edge SHALL capture cmd, word index and wdata, then go to WAIT (WAIT_CYCLES > 0) or ACK (WAIT_CYCLES = 0).
REQ-014 WAIT: a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; at 0, go to ACK.
REQ-015 ACK: o_s_cb_ack = 1 for exactly one cycle; next state is always IDLE.
REQ-016 Latency: req sampled at edge N -> o_s_cb_ack high during cycle N+1+WAIT_CYCLES.
REQ-017 Write: captured wdata SHALL be stored to the captured word on the edge entering ACK; rdata = 0 during write ack.
REQ-018 Read: o_s_cb_rdata SHALL hold the word value as of entering ACK; 0 whenever ack = 0.
REQ-019 Address bits above the index and addr[1:0] SHALL be ignored; indices wrap modulo DEPTH.
REQ-020 Inputs SHALL be ignored in WAIT and ACK; req dropped mid-transaction SHALL NOT abort it.
REQ-021 req high in IDLE on the cycle after ack SHALL start a new transaction (back-to-back allowed; min 2+WAIT_CYCLES cycles per transfer).
REQ-022 Read-after-write to the same word SHALL return the newly written value.

Reset
REQ-023 arst = 0 at an edge SHALL force state IDLE, counter 0, o_s_cb_ack = 0, o_s_cb_rdata = 0, all words = INIT_VAL.
REQ-024 Reset mid-transaction SHALL abort it: no ack, no memory write.
REQ-025 While arst = 0, i_cb_s_req SHALL be ignored; the first capture is on the first edge with arst = 1.

Configuration
REQ-026 Macro CB_SLAVE_MEM_STATS_EN defined: add outputs o_rd_cnt[15:0] and o_wr_cnt[15:0], each +1 on every read/write ack, saturating at 16'hFFFF, cleared by reset.
REQ-027 Macro not defined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-028 WAIT_CYCLES=2; write addr 0x0000_0004, data 0xA5A5_0001 -> ack exactly 3 cycles after req edge; read same addr -> rdata 0xA5A5_0001 in ack cycle.
REQ-029 WAIT_CYCLES=0; read after reset -> ack on cycle N+1, rdata = INIT_VAL.
REQ-030 DEPTH=16; write addr 0x0000_0040 data 0x1234_5678 -> read of addr 0x0000_0000 returns 0x1234_5678 (wrap).
REQ-031 req dropped one cycle after capture -> ack still issued at N+1+WAIT_CYCLES, write committed.
REQ-032 arst = 0 during WAIT of a write to addr 0x8 -> no ack; later read of 0x8 returns INIT_VAL.
REQ-033 CB_SLAVE_MEM_STATS_EN defined; 3 writes + 2 reads -> o_wr_cnt = 3, o_rd_cnt = 2; reset -> both 0.
